// File: rtl/servo_pwm_bank_pkg.sv
// Shared constants, FSM state type and pulse-limit helper for the
// eight-channel servo PWM bank.
package servo_pkg;

    localparam int NUM_CH          = 8;
    localparam int DUTY_W          = 8;
    localparam int LIM_W           = 10;
    localparam int TICK_DIV_DEF    = 195;
    localparam int MIN_TICKS_DEF   = 256;
    localparam int FRAME_TICKS_DEF = 5120;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last tick count (exclusive) during which the pulse is high.
    // MIN_TICKS + 255 always fits in 10 bits, so no overflow.
    function automatic logic [LIM_W-1:0] pulse_limit(
        input int unsigned         min_ticks,
        input logic [DUTY_W-1:0]   duty
    );
        return LIM_W'(min_ticks) + LIM_W'(duty);
    endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// Control/status bundle of the servo PWM bank.
// master: drives enable/dutyIn, observes pwmOut/frameStart; slave: the bank.
interface servo_pwm_bank_if;
    import servo_pkg::*;

    logic                       enable;
    logic [NUM_CH*DUTY_W-1:0]   dutyIn;
    logic [NUM_CH-1:0]          pwmOut;
    logic                       frameStart;

    modport master (
        output enable,
        output dutyIn,
        input  pwmOut,
        input  frameStart
    );

    modport slave (
        input  enable,
        input  dutyIn,
        output pwmOut,
        output frameStart
    );

endinterface

// File: rtl/servo_pwm_bank_channel.sv
// One servo channel: per-frame shadow duty register and registered
// comparator. Ports: clk, reset_n, load, run, duty, tcount -> pwm.
module servo_channel
    import servo_pkg::*;
#(
    parameter int CW        = 13,
    parameter int MIN_TICKS = MIN_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              run,
    input  logic [DUTY_W-1:0] duty,
    input  logic [CW-1:0]     tcount,
    output logic              pwm
);

    logic [DUTY_W-1:0] shadow;
    logic [LIM_W-1:0]  limit;
    logic              below;

    assign limit = pulse_limit(MIN_TICKS, shadow);
    // Zero-extend both sides to a common width for the compare.
    assign below = ({{LIM_W{1'b0}}, tcount} < {{CW{1'b0}}, limit});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) begin
                shadow <= duty;
            end
            pwm <= run & below;
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Eight-channel RC servo pulse generator: prescaler, frame counter and
// IDLE/RUN FSM. Ports: clk, reset_n, bus (enable, dutyIn, pwmOut, frameStart).
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int MIN_TICKS   = MIN_TICKS_DEF,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    servo_pwm_bank_if.slave    bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(FRAME_TICKS);

    state_t                   state;
    state_t                   state_nx;
    logic [PW-1:0]            presc;
    logic [CW-1:0]            tcount;
    logic [NUM_CH*DUTY_W-1:0] sync1;
    logic [NUM_CH*DUTY_W-1:0] sync2;
    logic                     fs_q;
    logic                     tick;
    logic                     wrap;
    logic                     load;
    logic                     run;
    logic [NUM_CH-1:0]        pwm;

    assign run  = (state == RUN);
    assign tick = (presc == PW'(TICK_DIV - 1));
    assign wrap = tick && (tcount == CW'(FRAME_TICKS - 1));

    // load marks the edge that enters the first cycle of a frame,
    // either from IDLE or at a wrap with enable still high.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (bus.enable) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            presc  <= '0;
            tcount <= '0;
            sync1  <= '0;
            sync2  <= '0;
            fs_q   <= 1'b0;
        end else begin
            state <= state_nx;
            sync1 <= bus.dutyIn;
            sync2 <= sync1;
            fs_q  <= load;
            if (run) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    tcount <= wrap ? '0 : tcount + CW'(1);
                end
            end else begin
                presc  <= '0;
                tcount <= '0;
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        servo_channel #(
            .CW        (CW),
            .MIN_TICKS (MIN_TICKS)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load),
            .run     (run),
            .duty    (sync2[n*DUTY_W +: DUTY_W]),
            .tcount  (tcount),
            .pwm     (pwm[n])
        );
    end

    assign bus.pwmOut     = pwm;
    assign bus.frameStart = fs_q;

endmodule
